// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame FSM states, scan-code prefixes, parity helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronises one asynchronous PS/2 pin and debounces it to a stable level.
// Latency: 2 sync flops + FILTER_LEN samples before a new level appears on 'level'.
// Backpressure: none; free-running sampler.
//
// Ports:
//   clk, rst  system clock, async active-high reset (state resets to 1 = bus idle)
//   pin       raw asynchronous pin
//   level     filtered level
module ps2_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with 'level'; the new
  // level is taken on the FILTER_LEN-th such sample, any agreeing sample
  // restarts the count so short glitches never get through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] != level) begin
        if (cnt == CW'(FILTER_LEN - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver with byte history and E0/F0 prefix decoding.
// Latency: byte_valid/key_valid exactly 1 clk after the filtered stop-bit kclk fall.
// Backpressure: none; outputs are single-cycle pulses, scan_code held until next key_valid.
//
// Ports:
//   clk, rst      system clock, async active-high reset
//   kclk, kdata   raw PS/2 pins (asynchronous)
//   keycodeout    last HIST_DEPTH accepted bytes, newest in [7:0]
//   byte_valid    pulse per accepted byte
//   scan_code, extended, released, key_valid   decoded key event
//   parity_err    pulse on odd-parity failure with a good stop bit
//   frame_err     pulse on bad start/stop bit or inter-bit timeout
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int HIST_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    kclk,
  input  logic                    kdata,
  output logic [8*HIST_DEPTH-1:0] keycodeout,
  output logic                    byte_valid,
  output logic [7:0]              scan_code,
  output logic                    extended,
  output logic                    released,
  output logic                    key_valid,
  output logic                    parity_err,
  output logic                    frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic kclk_f;
  logic kdata_f;
  logic kclk_prev;
  logic bit_event;

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_kclk_filt (
    .clk   (clk),
    .rst   (rst),
    .pin   (kclk),
    .level (kclk_f)
  );

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_kdata_filt (
    .clk   (clk),
    .rst   (rst),
    .pin   (kdata),
    .level (kdata_f)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) kclk_prev <= 1'b1;
    else     kclk_prev <= kclk_f;
  end

  assign bit_event = kclk_prev & ~kclk_f;

  // ---------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------
  ps2_state_t    state, state_n;
  logic [7:0]    shift, shift_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic          par_bit, par_bit_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          accept, perr, ferr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      par_bit <= par_bit_n;
      to_cnt  <= to_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    par_bit_n = par_bit;
    to_cnt_n  = to_cnt;
    accept    = 1'b0;
    perr      = 1'b0;
    ferr      = 1'b0;

    case (state)
      IDLE: begin
        // A high start bit is noise on an idle bus; just wait for a real start.
        if (bit_event && !kdata_f) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (bit_event) begin
          shift_n   = {kdata_f, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (bit_event) begin
          par_bit_n = kdata_f;
          state_n   = STOP;
        end
      end
      STOP: begin
        if (bit_event) begin
          state_n = IDLE;
          // A bad stop bit masks any parity outcome.
          if (!kdata_f)                          ferr   = 1'b1;
          else if (!odd_parity_ok(shift, par_bit)) perr = 1'b1;
          else                                   accept = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Inter-bit watchdog: only runs while a frame is open.
    if (state == IDLE) begin
      to_cnt_n = '0;
    end else if (bit_event) begin
      to_cnt_n = '0;
    end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
      ferr     = 1'b1;
      state_n  = IDLE;
      to_cnt_n = '0;
    end else begin
      to_cnt_n = to_cnt + TW'(1);
    end
  end

  // ---------------------------------------------------------------
  // Byte history and prefix decoder
  // ---------------------------------------------------------------
  logic [8*HIST_DEPTH-1:0] hist_next;

  generate
    if (HIST_DEPTH == 1) begin : g_hist_one
      assign hist_next = shift;
    end else begin : g_hist_shift
      assign hist_next = {keycodeout[8*HIST_DEPTH-9:0], shift};
    end
  endgenerate

  logic ext_flag;
  logic rel_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keycodeout <= '0;
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      key_valid  <= 1'b0;
      scan_code  <= '0;
      extended   <= 1'b0;
      released   <= 1'b0;
      ext_flag   <= 1'b0;
      rel_flag   <= 1'b0;
    end else begin
      byte_valid <= accept;
      parity_err <= perr;
      frame_err  <= ferr;
      key_valid  <= 1'b0;
      if (accept) begin
        keycodeout <= hist_next;
        // Prefix flags persist across error pulses and repeated prefixes.
        if (shift == PS2_EXT) begin
          ext_flag <= 1'b1;
        end else if (shift == PS2_BRK) begin
          rel_flag <= 1'b1;
        end else begin
          scan_code <= shift;
          extended  <= ext_flag;
          released  <= rel_flag;
          key_valid <= 1'b1;
          ext_flag  <= 1'b0;
          rel_flag  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
module tb_ps2_frame_receiver;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 300;
  localparam int HIST_DEPTH  = 4;
  localparam int HALF        = 20;

  logic        clk;
  logic        rst;
  logic        kclk;
  logic        kdata;
  logic [31:0] keycodeout;
  logic        byte_valid;
  logic [7:0]  scan_code;
  logic        extended;
  logic        released;
  logic        key_valid;
  logic        parity_err;
  logic        frame_err;

  ps2_frame_receiver #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .HIST_DEPTH  (HIST_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .kclk       (kclk),
    .kdata      (kdata),
    .keycodeout (keycodeout),
    .byte_valid (byte_valid),
    .scan_code  (scan_code),
    .extended   (extended),
    .released   (released),
    .key_valid  (key_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int mon_bv = 0, mon_kv = 0, mon_pe = 0, mon_fe = 0, kv_orphan = 0;
  int last_bv_cyc = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid) begin
        mon_bv      <= mon_bv + 1;
        last_bv_cyc <= cyc;
      end
      if (key_valid)               mon_kv    <= mon_kv + 1;
      if (key_valid && !byte_valid) kv_orphan <= kv_orphan + 1;
      if (parity_err)              mon_pe    <= mon_pe + 1;
      if (frame_err)               mon_fe    <= mon_fe + 1;
    end
  end

  // Reference model: what the host should have decoded so far.
  logic [31:0] exp_hist;
  logic [7:0]  exp_scan;
  logic        exp_ext, exp_rel, m_ext, m_rel;
  int          exp_bv = 0, exp_kv = 0, exp_pe = 0, exp_fe = 0;
  int          total = 0, bad = 0;
  int          fall_cyc = 0;

  task automatic model_reset();
    exp_hist = '0; exp_scan = '0;
    exp_ext = 1'b0; exp_rel = 1'b0; m_ext = 1'b0; m_rel = 1'b0;
  endtask

  task automatic model_accept(input logic [7:0] b);
    exp_hist = {exp_hist[23:0], b};
    exp_bv++;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else begin
      exp_scan = b; exp_ext = m_ext; exp_rel = m_rel;
      m_ext = 1'b0; m_rel = 1'b0;
      exp_kv++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, "/hist"},     keycodeout, exp_hist);
    chk({ctx, "/scan"},     {24'd0, scan_code}, {24'd0, exp_scan});
    chk({ctx, "/ext"},      {31'd0, extended}, {31'd0, exp_ext});
    chk({ctx, "/rel"},      {31'd0, released}, {31'd0, exp_rel});
    chk({ctx, "/n_byte"},   mon_bv, exp_bv);
    chk({ctx, "/n_key"},    mon_kv, exp_kv);
    chk({ctx, "/n_parerr"}, mon_pe, exp_pe);
    chk({ctx, "/n_frmerr"}, mon_fe, exp_fe);
    chk({ctx, "/kv_alone"}, kv_orphan, 0);
  endtask

  // One PS/2 bit: data changes while kclk is high, device drops kclk mid-cell.
  task automatic drive_bit(input logic v, input logic glitch);
    @(posedge clk); #1 kdata = v;
    repeat (HALF / 2) @(posedge clk);
    if (glitch) begin
      #1 kclk = 1'b0; @(posedge clk); #1 kclk = 1'b1;
    end
    repeat (HALF / 2) @(posedge clk);
    #1 kclk = 1'b0; fall_cyc = cyc;
    repeat (HALF / 2) @(posedge clk);
    if (glitch) begin
      #1 kclk = 1'b1; @(posedge clk); #1 kclk = 1'b0;
    end
    repeat (HALF / 2) @(posedge clk);
    #1 kclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                            input logic glitch, input int nbits);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) drive_bit(bits[i], glitch);
    #1 kdata = 1'b1;
    repeat (HALF) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] rb;
    int         kind;
    rst = 1'b1; kclk = 1'b1; kdata = 1'b1;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst/hist", keycodeout, 32'h0);
    chk("rst/pulses", {27'd0, byte_valid, key_valid, parity_err, frame_err, extended},
        32'h0);
    chk("rst/scan", {24'd0, scan_code}, 32'h0);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // Single clean key.
    send_frame(8'h1D, 1'b0, 1'b1, 1'b0, 11); model_accept(8'h1D);
    check_all("key1D");
    chk("latency", last_bv_cyc - fall_cyc, FILTER_LEN + 3);

    // Same frame with one-cycle kclk glitches in both half-cells.
    send_frame(8'h1D, 1'b0, 1'b1, 1'b1, 11); model_accept(8'h1D);
    check_all("glitch1D");

    // Extended release sequence yields a single key event.
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0, 11); model_accept(8'hE0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 11); model_accept(8'hF0);
    chk("pre_kv", mon_kv, exp_kv);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0, 11); model_accept(8'h75);
    check_all("E0F075");
    chk("E0F075/hist_abs", keycodeout, 32'h1DE0F075);

    // Parity error, then stop-bit error masking a parity error.
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 11); exp_pe++;
    check_all("parerr");
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 11); exp_fe++;
    check_all("stoperr");

    // Truncated frame times out, next frame is clean.
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 5);
    repeat (TIMEOUT_CYC + 60) @(posedge clk);
    @(negedge clk); exp_fe++;
    check_all("timeout");
    send_frame(8'h23, 1'b0, 1'b1, 1'b0, 11); model_accept(8'h23);
    check_all("after_to");

    // History window.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(8'h11 * i), 1'b0, 1'b1, 1'b0, 11);
      model_accept(8'(8'h11 * i));
    end
    chk("hist5", keycodeout, 32'h22334455);
    check_all("hist5");

    // Repeated prefix, error in between must not drop the flag.
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0, 11); model_accept(8'hE0);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0, 11); model_accept(8'hE0);
    send_frame(8'h6B, 1'b1, 1'b1, 1'b0, 11); exp_pe++;
    send_frame(8'h6B, 1'b0, 1'b1, 1'b0, 11); model_accept(8'h6B);
    check_all("ext_keep");
    chk("ext_keep/ext1", {31'd0, extended}, 32'd1);

    // Random traffic.
    for (int n = 0; n < 24; n++) begin
      rb   = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hF0;
      if (kind == 0) begin
        send_frame(rb, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 11); exp_pe++;
      end else if (kind == 1) begin
        send_frame(rb, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 11); exp_fe++;
      end else begin
        send_frame(rb, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 11); model_accept(rb);
      end
      check_all($sformatf("rnd%0d", n));
    end

    // Reset in the middle of a frame: silent abandon.
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0, 11); model_accept(8'hE0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 6);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (TIMEOUT_CYC + 60) @(posedge clk);
    @(negedge clk);
    check_all("midrst");
    send_frame(8'h4D, 1'b0, 1'b1, 1'b0, 11); model_accept(8'h4D);
    check_all("post_rst");
    chk("post_rst/ext0", {31'd0, extended}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
